// File: rtl/instruction_execute_unit_pkg.sv
// Shared pipeline definitions for the execute stage.
// ALU opcodes, forward selects, control bit positions.
package instruction_execute_unit_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_RES_SRC_HI = 5;
  localparam int CTRL_RES_SRC_LO = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_JUMP       = 2;
  localparam int CTRL_BRANCH     = 1;
  localparam int CTRL_ALU_SRC    = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [6:0]  ctrl;
    logic [2:0]  alu_ctrl;
  } id_ex_t;

  // Reserved encoding 11 falls back to the register value.
  function automatic logic [31:0] fwd_mux(
    input logic [1:0]  sel,
    input logic [31:0] reg_v,
    input logic [31:0] wb_v,
    input logic [31:0] mem_v
  );
    logic [31:0] v;
    v = reg_v;
    case (fwd_sel_e'(sel))
      FWD_WB:  v = wb_v;
      FWD_MEM: v = mem_v;
      default: v = reg_v;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/instruction_execute_unit_alu.sv
// Combinational ALU with zero flag.
// Shifts use only the low five bits of operand B.
module alu_unit
  import instruction_execute_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [2:0]      i_op,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  logic [XLEN-1:0] w_res;
  logic            w_lt;

  assign w_lt = $signed(i_a) < $signed(i_b);

  // Operation select.
  always_comb begin
    w_res = '0;
    case (alu_op_e'(i_op))
      ALU_ADD: w_res = i_a + i_b;
      ALU_SUB: w_res = i_a - i_b;
      ALU_AND: w_res = i_a & i_b;
      ALU_OR:  w_res = i_a | i_b;
      ALU_XOR: w_res = i_a ^ i_b;
      ALU_SLT: w_res = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL: w_res = i_a << i_b[4:0];
      ALU_SRL: w_res = i_a >> i_b[4:0];
      default: w_res = '0;
    endcase
  end

  assign o_result = w_res;
  assign o_zero   = (w_res == '0);

endmodule

// File: rtl/instruction_execute_unit.sv
// Execute stage: ID/EX register, forwarding, ALU, branch.
// Flush and reset both load an all-zero bubble.
module instruction_execute_unit
  import instruction_execute_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instruction_decode,
  input  logic [XLEN-1:0] pc_decode,
  input  logic [XLEN-1:0] pc_plus4_decode,
  input  logic [XLEN-1:0] read_data1_decode,
  input  logic [XLEN-1:0] read_data2_decode,
  input  logic [XLEN-1:0] immediate_extended_decode,
  input  logic [6:0]      control_decode,
  input  logic [2:0]      alu_control_decode,
  input  logic            flush_execute,
  input  logic [1:0]      forward_a_execute,
  input  logic [1:0]      forward_b_execute,
  input  logic [XLEN-1:0] alu_result_memory,
  input  logic [XLEN-1:0] result_writeback,
  output logic [4:0]      rs1_execute,
  output logic [4:0]      rs2_execute,
  output logic [4:0]      rd_execute,
  output logic [XLEN-1:0] alu_result_execute,
  output logic [XLEN-1:0] write_data_execute,
  output logic [XLEN-1:0] pc_plus4_execute,
  output logic [XLEN-1:0] pc_target_execute,
  output logic            pc_src_execute,
  output logic            reg_write_execute,
  output logic            mem_write_execute,
  output logic [1:0]      result_src_execute
);

  id_ex_t          r_idex;
  id_ex_t          w_capture;
  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_res;
  logic            w_zero;
  logic            w_funct3_0;
  logic            w_jump;
  logic            w_branch;
  logic            w_unused_instr;

  assign w_capture = '{
    instr:    instruction_decode,
    pc:       pc_decode,
    pc4:      pc_plus4_decode,
    rd1:      read_data1_decode,
    rd2:      read_data2_decode,
    imm:      immediate_extended_decode,
    ctrl:     control_decode,
    alu_ctrl: alu_control_decode
  };

  // ID/EX register: reset beats flush beats capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idex <= '0;
    end else if (flush_execute) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_capture;
    end
  end

  assign rs1_execute = r_idex.instr[19:15];
  assign rs2_execute = r_idex.instr[24:20];
  assign rd_execute  = r_idex.instr[11:7];
  assign w_funct3_0  = r_idex.instr[12];

  assign w_unused_instr = ^{r_idex.instr[31:25],
                            r_idex.instr[14:13],
                            r_idex.instr[6:0]};

  assign w_src_a = fwd_mux(forward_a_execute, r_idex.rd1,
                           result_writeback, alu_result_memory);
  assign w_fwd_b = fwd_mux(forward_b_execute, r_idex.rd2,
                           result_writeback, alu_result_memory);
  assign w_src_b = r_idex.ctrl[CTRL_ALU_SRC] ? r_idex.imm
                                             : w_fwd_b;

  alu_unit #(
    .XLEN (XLEN)
  ) u_alu (
    .i_a      (w_src_a),
    .i_b      (w_src_b),
    .i_op     (r_idex.alu_ctrl),
    .o_result (w_alu_res),
    .o_zero   (w_zero)
  );

  assign w_jump   = r_idex.ctrl[CTRL_JUMP];
  assign w_branch = r_idex.ctrl[CTRL_BRANCH];

  assign alu_result_execute = w_alu_res;
  assign write_data_execute = w_fwd_b;
  assign pc_plus4_execute   = r_idex.pc4;
  assign pc_target_execute  = r_idex.pc + r_idex.imm;
  assign pc_src_execute     = w_jump |
                              (w_branch & (w_zero ^ w_funct3_0));
  assign reg_write_execute  = r_idex.ctrl[CTRL_REG_WRITE];
  assign mem_write_execute  = r_idex.ctrl[CTRL_MEM_WRITE];
  assign result_src_execute =
    r_idex.ctrl[CTRL_RES_SRC_HI:CTRL_RES_SRC_LO];

endmodule

// File: doc/instruction_execute_unit.md
INSTRUCTION_EXECUTE_UNIT -- requirements
Module: instruction_execute_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 SHALL have instruction_decode, pc_decode, pc_plus4_decode  input  32 each  decode-stage instruction, PC and PC+4.
REQ-005 SHALL have read_data1_decode, read_data2_decode, immediate_extended_decode  input  32 each  register operands and extended immediate.
REQ-006 SHALL have control_decode  input  7  packed {reg_write, result_src[1:0], mem_write, jump, branch, alu_src}.
REQ-007 SHALL have alu_control_decode  input  3  ALU operation select.
REQ-008 SHALL have flush_execute  input  1  load bubble into the execute register.
REQ-009 SHALL have forward_a_execute, forward_b_execute  input  2 each  operand source: 00 register, 01 writeback, 10 memory.
REQ-010 SHALL have alu_result_memory, result_writeback  input  32 each  forwarding data.
REQ-011 SHALL have rs1_execute, rs2_execute, rd_execute  output  5 each  registered register indices for hazard unit.
REQ-012 SHALL have alu_result_execute, write_data_execute, pc_plus4_execute, pc_target_execute  output  32 each  results to memory stage.
REQ-013 SHALL have pc_src_execute  output  1  redirect fetch to pc_target_execute.
REQ-014 SHALL have reg_write_execute, mem_write_execute  output  1 each; result_src_execute  output  2.

Function
REQ-015 SHALL hold an ID/EX register capturing all decode inputs on each clk rising edge; all execute outputs derive from it, giving exactly one cycle latency.
REQ-016 SHALL extract rs1/rs2/rd from registered instruction bits [19:15]/[24:20]/[11:7] and funct3 bit [12] for branch sense.
REQ-017 SHALL, when flush_execute=1, load zero into every register field (instruction, PCs, operands, immediate, control, alu_control).
REQ-018 SHALL give flush_execute priority over capture; there is no stall input, the register never holds.
REQ-019 SHALL select SrcA by forward_a_execute: 00 read_data1, 01 result_writeback, 10 alu_result_memory, 11 read_data1.
REQ-020 SHALL select forwarded B identically from read_data2; write_data_execute SHALL equal forwarded B.
REQ-021 SHALL use SrcB = immediate when alu_src=1, else forwarded B.
REQ-022 SHALL implement ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt signed (result 0/1), 110 sll by SrcB[4:0], 111 srl by SrcB[4:0]; add/sub wrap modulo 2^32.
REQ-023 SHALL assert zero when alu_result_execute==0.
REQ-024 SHALL compute pc_target_execute = registered pc + registered immediate, modulo 2^32.
REQ-025 SHALL drive pc_src_execute = jump | (branch & (zero XOR funct3[0])) (beq/bne).
REQ-026 SHALL pass reg_write, result_src, mem_write, pc_plus4 straight from the register.
REQ-027 SHALL keep ALU, forwarding and branch logic combinational; forwarding inputs take effect in the same cycle.

Reset
REQ-028 SHALL, when reset=0 at a clk edge, clear the whole ID/EX register to zero, overriding flush and capture.
REQ-029 SHALL therefore drive all outputs to 0 after reset, except combinational forwarded values, which follow forwarding inputs when forward_*!=00.
REQ-030 SHALL, on mid-operation reset, discard the in-flight instruction; first capture occurs on the first edge with reset=1.

Structure
REQ-031 SHALL take the ALU opcodes, forward-select encodings and control_decode bit positions from the shared pipeline package.
REQ-032 SHALL instantiate one sub-module, alu_unit (combinational ALU plus zero flag); all else stays in this module.

Verification
REQ-033 Reset: hold reset=0 two cycles with random inputs -> all registered outputs 0, pc_src_execute=0.
REQ-034 Add-immediate: operand1=5, immediate=-3, alu_src=1, alu 000 -> next cycle alu_result_execute=2, rd_execute from instr[11:7].
REQ-035 Forwarding: forward_a=10, alu_result_memory=0x10, forward_b=01, result_writeback=0x4, op sub -> 0xC, write_data_execute=0x4.
REQ-036 Branch: beq, operands 7 and 7, pc=0x100, imm=0x20 -> pc_src=1, pc_target=0x120; operands 7 and 8 -> pc_src=0.
REQ-037 Flush priority: flush_execute=1 with jump decoded -> next cycle all control outputs 0, pc_src_execute=0.
REQ-038 Edges: slt 0xFFFFFFFF vs 1 -> 1; add 0xFFFFFFFF+1 -> 0 with zero; sll 1 by SrcB=33 -> 2.
